// File: rtl/fft2d_tile_sched_if.sv
// Requester / engine bus of the 2D-FFT tile scheduler.
// master: requesters plus engine (drive rows and fft_outvalid).
// slave:  the scheduler itself.
interface fft2d_tile_sched_if #(
    parameter int NREQ    = 2,
    parameter int DATALEN = 16,
    parameter int FFTCHNL = 8
) ();
    localparam int ROWW = FFTCHNL * 2 * DATALEN;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*ROWW-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      gnt;
    logic                 fft_next;
    logic [ROWW-1:0]      fft_data;
    logic                 fft_outvalid;
    logic                 out_valid;
    logic [IW-1:0]        out_tag;
    logic                 busy;
    logic                 err;

    modport master (
        output req_valid, req_data, fft_outvalid,
        input  req_ready, gnt, fft_next, fft_data, out_valid, out_tag, busy, err
    );

    modport slave (
        input  req_valid, req_data, fft_outvalid,
        output req_ready, gnt, fft_next, fft_data, out_valid, out_tag, busy, err
    );
endinterface

// File: rtl/fft2d_tile_sched.sv
// Shares one 8x8 2D-FFT engine between NREQ requesters: arbitrates whole
// tiles, pulses fft_next, streams the owner's rows and enforces the
// tile-to-tile gap. A tag FIFO remembers the owner of every tile in flight
// so the engine's output-valid pulse is returned with the right owner.
// Optional feature: define FFT2D_SCHED_PRIO_EN to give requester 0 strict
// priority (others round-robin among themselves); default is pure round-robin.
module fft2d_tile_sched #(
    parameter int NREQ     = 2,
    parameter int DATALEN  = 16,
    parameter int FFTCHNL  = 8,
    parameter int ROWS     = 8,
    parameter int TILE_GAP = 16,
    parameter int TAGDEPTH = 4
) (
    input logic                clk,
    input logic                rstn,
    fft2d_tile_sched_if.slave  bus
);
    localparam int ROWW     = FFTCHNL * 2 * DATALEN;
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW       = $clog2(TAGDEPTH);
    localparam int CW       = TW + 1;
    localparam int RW       = $clog2(ROWS + 1);
    localparam int GW       = $clog2(TILE_GAP + 1);
    // GAP residency; saturates so the gap is never shorter than one cycle
    localparam int GAP_LOAD = (TILE_GAP - ROWS - 2 > 0) ? (TILE_GAP - ROWS - 2) : 0;

    typedef enum logic [1:0] {IDLE, START, STREAM, GAP} state_t;

    state_t          state_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] req_ready_reg;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic            fft_next_reg;
    logic [ROWW-1:0] fft_data_reg;
    logic            out_valid_reg;
    logic [IW-1:0]   out_tag_reg;
    logic            err_reg;
    logic [RW-1:0]   row_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;

    logic [IW-1:0]   tag_mem [TAGDEPTH];
    logic [TW-1:0]   wr_ptr_reg;
    logic [TW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   tag_cnt_reg;

    logic [ROWW-1:0] row_arr [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    logic            tag_full;
    logic            tag_empty;
    logic            push;
    logic            pop;

    // Unpack the flat request bus into one row per requester
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rows
            assign row_arr[gi] = bus.req_data[gi*ROWW +: ROWW];
        end
    endgenerate

    // Round-robin search starting one past the last granted requester
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_idx = IW'((int'(rr_ptr_reg) + i) % NREQ);
`ifdef FFT2D_SCHED_PRIO_EN
            if (!win_found && (cand_idx != '0) && bus.req_valid[cand_idx]) begin
`else
            if (!win_found && bus.req_valid[cand_idx]) begin
`endif
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`ifdef FFT2D_SCHED_PRIO_EN
        if (bus.req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    assign tag_full  = (tag_cnt_reg == CW'(TAGDEPTH));
    assign tag_empty = (tag_cnt_reg == '0);
    assign push      = (state_reg == IDLE) && win_found && !tag_full;
    assign pop       = bus.fft_outvalid;

    // Tag storage: plain array, written on grant, read registered on pop
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr_reg] <= win_idx;
    end

    // Tile FSM, tag FIFO bookkeeping and all registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            req_ready_reg <= '0;
            owner_reg     <= '0;
            rr_ptr_reg    <= IW'(NREQ - 1);
            fft_next_reg  <= 1'b0;
            fft_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_tag_reg   <= '0;
            err_reg       <= 1'b0;
            row_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            tag_cnt_reg   <= '0;
        end else begin
            out_valid_reg <= pop;
            if (pop) begin
                if (tag_empty) begin
                    out_tag_reg <= '0;
                    err_reg     <= 1'b1;
                end else begin
                    out_tag_reg <= tag_mem[rd_ptr_reg];
                    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                end
            end
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            // An underflowing pop removes nothing, so only a real pop counts
            if (push && !(pop && !tag_empty))
                tag_cnt_reg <= tag_cnt_reg + 1'b1;
            else if (!push && pop && !tag_empty)
                tag_cnt_reg <= tag_cnt_reg - 1'b1;

            case (state_reg)
                IDLE: begin
                    fft_data_reg <= '0;
                    if (push) begin
                        gnt_reg      <= NREQ'(1) << win_idx;
                        owner_reg    <= win_idx;
                        fft_next_reg <= 1'b1;
                        state_reg    <= START;
`ifdef FFT2D_SCHED_PRIO_EN
                        if (win_idx != '0)
                            rr_ptr_reg <= win_idx;
`else
                        rr_ptr_reg <= win_idx;
`endif
                    end
                end
                START: begin
                    fft_next_reg  <= 1'b0;
                    fft_data_reg  <= '0;
                    req_ready_reg <= gnt_reg;
                    row_cnt_reg   <= '0;
                    state_reg     <= STREAM;
                end
                STREAM: begin
                    // The engine cannot stall: a missing row becomes zeros
                    if (bus.req_valid[owner_reg]) begin
                        fft_data_reg <= row_arr[owner_reg];
                    end else begin
                        fft_data_reg <= '0;
                        err_reg      <= 1'b1;
                    end
                    if (row_cnt_reg == RW'(ROWS - 1)) begin
                        gnt_reg       <= '0;
                        req_ready_reg <= '0;
                        gap_cnt_reg   <= GW'(GAP_LOAD);
                        state_reg     <= GAP;
                    end else begin
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    fft_data_reg <= '0;
                    if (gap_cnt_reg <= GW'(1))
                        state_reg <= IDLE;
                    else
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.gnt       = gnt_reg;
    assign bus.fft_next  = fft_next_reg;
    assign bus.fft_data  = fft_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_tag   = out_tag_reg;
    assign bus.busy      = (state_reg != IDLE) || (tag_cnt_reg != '0);
    assign bus.err       = err_reg;
endmodule
